// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared widths, saturation limit, pipeline depth and gradient helpers for the Sobel filter
package filter_pkg;

    localparam int PIX_W      = 8;
    localparam int COORD_W    = 12;
    localparam int SAT_MAX    = 255;
    localparam int PIPE_DEPTH = 4;
    localparam int GRAD_W     = 11;

    typedef logic [PIX_W-1:0]          pix_t;
    typedef logic [COORD_W-1:0]        coord_t;
    typedef logic signed [GRAD_W-1:0]  grad_t;

    function automatic grad_t widen(input pix_t p);
        return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction

    // |gx|+|gy| never exceeds 2040, so one extra bit holds the sum before clamping
    function automatic pix_t sat_mag(input grad_t gx, input grad_t gy);
        logic [GRAD_W-1:0] ax;
        logic [GRAD_W-1:0] ay;
        logic [GRAD_W:0]   sum;
        ax  = gx[GRAD_W-1] ? $unsigned(-gx) : $unsigned(gx);
        ay  = gy[GRAD_W-1] ? $unsigned(-gy) : $unsigned(gy);
        sum = {1'b0, ax} + {1'b0, ay};
        if (|sum[GRAD_W:PIX_W]) begin
            return pix_t'(SAT_MAX);
        end
        return sum[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_linebuf.sv
// rtl/sobel_linebuf.sv - two LINE_W x 8 synchronous-read line buffers, read-before-write, LB1 takes old LB0
module sobel_linebuf
    import filter_pkg::*;
#(
    parameter int LINE_W = 640,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  pix_t              din,
    output pix_t              q0,
    output pix_t              q1
);

    localparam int IDX_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    pix_t             mem0 [LINE_W];
    pix_t             mem1 [LINE_W];
    logic [IDX_W-1:0] idx;
    logic             in_range;

    assign idx      = addr[IDX_W-1:0];
    // a second guard so an aliased address can never overwrite a live column
    assign in_range = {1'b0, addr} < (ADDR_W+1)'(LINE_W);

    always_ff @(posedge clk) begin
        if (en) begin
            q0 <= mem0[idx];
            q1 <= mem1[idx];
            if (we && in_range) begin
                mem0[idx] <= din;
                mem1[idx] <= mem0[idx];
            end
        end
    end

endmodule

// File: rtl/sobel_filter.sv
// rtl/sobel_filter.sv - 4-stage streaming 3x3 Sobel edge magnitude; SOBEL_THRESHOLD_EN adds THRESH binarisation
module sobel_filter
    import filter_pkg::*;
#(
    parameter int LINE_W = 640,
    parameter int ADDR_W = 12
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [COORD_W-1:0] POSX,
    input  logic [COORD_W-1:0] POSY,
    input  logic               READY,
    output logic               RDEN,
    input  logic [PIX_W-1:0]   IN_R,
    input  logic [PIX_W-1:0]   IN_G,
    input  logic [PIX_W-1:0]   IN_B,
`ifdef SOBEL_THRESHOLD_EN
    input  logic [PIX_W-1:0]   THRESH,
`endif
    output logic               WREN,
    output logic [PIX_W-1:0]   OUT_R,
    output logic [PIX_W-1:0]   OUT_G,
    output logic [PIX_W-1:0]   OUT_B
);

    logic                  accept;
    logic                  in_line;
    logic                  border_in;
    logic [ADDR_W-1:0]     lb_addr;
    pix_t                  lb_q0;
    pix_t                  lb_q1;
    logic                  unused_chan;

    logic [PIPE_DEPTH-1:0] valid_sr;
    logic [PIPE_DEPTH-2:0] border_sr;
    pix_t                  s1_pix;
    pix_t                  win [3][3];
    grad_t                 gx;
    grad_t                 gy;
    grad_t                 gx_n;
    grad_t                 gy_n;
    pix_t                  mag;
    pix_t                  res;
    pix_t                  out_pix;

    assign RDEN        = READY;
    assign accept      = READY;
    assign unused_chan = ^{IN_R, IN_B};

    assign in_line   = POSX < COORD_W'(LINE_W);
    assign border_in = (POSX < COORD_W'(2)) || (POSY < COORD_W'(2)) || !in_line;
    assign lb_addr   = POSX[ADDR_W-1:0];

    sobel_linebuf #(
        .LINE_W (LINE_W),
        .ADDR_W (ADDR_W)
    ) u_linebuf (
        .clk  (CLK),
        .en   (accept),
        .we   (accept && in_line),
        .addr (lb_addr),
        .din  (IN_G),
        .q0   (lb_q0),
        .q1   (lb_q1)
    );

    // valid and border flags ride alongside the data, one bit per stage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_sr  <= '0;
            border_sr <= '0;
            s1_pix    <= '0;
        end else begin
            valid_sr  <= {valid_sr[PIPE_DEPTH-2:0], accept};
            border_sr <= {border_sr[PIPE_DEPTH-3:0], border_in};
            if (accept) begin
                s1_pix <= IN_G;
            end
        end
    end

    // row 0 is two lines up (LB1), row 2 is the current line
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (valid_sr[0]) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb_q1;
            win[1][2] <= lb_q0;
            win[2][2] <= s1_pix;
        end
    end

    always_comb begin
        gx_n = (widen(win[0][2]) - widen(win[0][0]))
             + ((widen(win[1][2]) - widen(win[1][0])) <<< 1)
             + (widen(win[2][2]) - widen(win[2][0]));
        gy_n = (widen(win[2][0]) - widen(win[0][0]))
             + ((widen(win[2][1]) - widen(win[0][1])) <<< 1)
             + (widen(win[2][2]) - widen(win[0][2]));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gx <= '0;
            gy <= '0;
        end else if (valid_sr[1]) begin
            gx <= gx_n;
            gy <= gy_n;
        end
    end

    always_comb begin
        mag = sat_mag(gx, gy);
`ifdef SOBEL_THRESHOLD_EN
        res = (mag >= THRESH) ? pix_t'(SAT_MAX) : '0;
`else
        res = mag;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_pix <= '0;
        end else if (valid_sr[2]) begin
            out_pix <= border_sr[2] ? '0 : res;
        end
    end

    assign WREN  = valid_sr[PIPE_DEPTH-1];
    assign OUT_R = out_pix;
    assign OUT_G = out_pix;
    assign OUT_B = out_pix;

endmodule

// File: tb/tb_sobel_filter.sv
// tb/tb_sobel_filter.sv - randomized self-checking bench for sobel_filter against a frame-level Sobel model
module tb_sobel_filter;

    localparam int W = 16;
    localparam int H = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic [11:0] POSX, POSY;
    logic        READY, RDEN, WREN;
    logic [7:0]  IN_R, IN_G, IN_B;
    logic [7:0]  OUT_R, OUT_G, OUT_B;
`ifdef SOBEL_THRESHOLD_EN
    logic [7:0]  THRESH;
`endif

    sobel_filter #(.LINE_W(W), .ADDR_W(4)) dut (
        .CLK(CLK), .RST(RST), .POSX(POSX), .POSY(POSY), .READY(READY), .RDEN(RDEN),
        .IN_R(IN_R), .IN_G(IN_G), .IN_B(IN_B),
`ifdef SOBEL_THRESHOLD_EN
        .THRESH(THRESH),
`endif
        .WREN(WREN), .OUT_R(OUT_R), .OUT_G(OUT_G), .OUT_B(OUT_B)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] img [H][W];
    int exp_q[$], got_q[$], rd_q[$], wr_q[$], step_ref[$];

    always @(posedge CLK) cyc = cyc + 1;

    always @(negedge CLK) begin
        if (RDEN === 1'b1) rd_q.push_back(cyc);
        if (WREN === 1'b1) begin
            got_q.push_back(int'({OUT_R, OUT_G, OUT_B}));
            wr_q.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Sobel of the full frame image, centre one pixel up-left of the newest pixel
    function automatic int ref_out(input int x, input int y);
        int gx, gy, m, wt;
        if (x < 2 || y < 2 || x >= W) return 0;
        gx = 0;
        gy = 0;
        for (int k = 0; k < 3; k++) begin
            wt = (k == 1) ? 2 : 1;
            gx += wt * (int'(img[y-2+k][x]) - int'(img[y-2+k][x-2]));
            gy += wt * (int'(img[y][x-2+k]) - int'(img[y-2][x-2+k]));
        end
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
`ifdef SOBEL_THRESHOLD_EN
        m = (m >= int'(THRESH)) ? 255 : 0;
`endif
        return m;
    endfunction

    task automatic clear_queues();
        exp_q.delete(); got_q.delete(); rd_q.delete(); wr_q.delete();
    endtask

    task automatic send(input int x, input int y, input logic [7:0] v);
        @(posedge CLK); #1;
        READY = 1'b1; POSX = 12'(x); POSY = 12'(y);
        IN_R = v; IN_G = v; IN_B = v;
    endtask

    task automatic idle();
        @(posedge CLK); #1;
        READY = 1'b0;
    endtask

    // mode 0 continuous, 1 READY toggling, 2 random gaps, 3 continuous plus an off-line pixel
    task automatic stream_frame(input int mode);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (mode == 1 && (x != 0 || y != 0)) idle();
                if (mode == 2) repeat ($urandom_range(0, 2)) idle();
                send(x, y, img[y][x]);
                exp_q.push_back(ref_out(x, y));
                if (mode == 3 && y == 2 && x == W - 1) begin
                    send(W, 2, ~img[2][0]);
                    exp_q.push_back(0);
                end
            end
        end
        idle();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 64) begin
            @(posedge CLK);
            n++;
        end
        repeat (6) @(posedge CLK);
        #1;
    endtask

    task automatic check_stream(input string name);
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL %s_count: got %0d outputs, want %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size() && i < rd_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] * 32'h010101) begin
                bad++;
                $display("FAIL %s_val[%0d]: got %06h want %06h", name, i, got_q[i], exp_q[i] * 32'h010101);
            end
            total++;
            if (wr_q[i] - rd_q[i] !== 4) begin
                bad++;
                $display("FAIL %s_lat[%0d]: got %0d want 4", name, i, wr_q[i] - rd_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if (WREN !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", WREN); end
        total++;
        if ({OUT_R, OUT_G, OUT_B} !== 24'h0) begin
            bad++; $display("FAIL reset_out: got %06h want 000000", {OUT_R, OUT_G, OUT_B});
        end
        READY = 1'b1; #1;
        total++;
        if (RDEN !== 1'b1) begin bad++; $display("FAIL rden_hi: got %b want 1", RDEN); end
        READY = 1'b0; #1;
        total++;
        if (RDEN !== 1'b0) begin bad++; $display("FAIL rden_lo: got %b want 0", RDEN); end
        RST = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        total++;
        if (wr_q.size() !== 0) begin bad++; $display("FAIL reset_idle_wren: got %0d pulses want 0", wr_q.size()); end
        clear_queues();
    endtask

    task automatic test_flat();
        clear_queues();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8'd100;
        stream_frame(0);
        wait_drain();
        total++;
        if (got_q.size() !== 128) begin bad++; $display("FAIL flat_pulses: got %0d want 128", got_q.size()); end
        check_stream("flat");
    endtask

    task automatic test_step();
        int n255;
        clear_queues();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = (x < 8) ? 8'd0 : 8'd255;
        stream_frame(0);
        wait_drain();
        check_stream("step");
        n255 = 0;
        foreach (got_q[i]) if (got_q[i] == 32'hFFFFFF) n255++;
        total++;
        if (n255 !== 12) begin bad++; $display("FAIL step_edges: got %0d saturated want 12", n255); end
        step_ref = got_q;
    endtask

    task automatic test_step_gaps();
        clear_queues();
        stream_frame(1);
        wait_drain();
        check_stream("step_gap");
        for (int i = 0; i < step_ref.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== step_ref[i]) begin
                bad++; $display("FAIL step_gap_same[%0d]: got %06h want %06h", i, got_q[i], step_ref[i]);
            end
        end
    endtask

    task automatic test_ramp(input int interior);
        int want;
        clear_queues();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8'(x);
        stream_frame(0);
        wait_drain();
        check_stream("ramp");
        for (int i = 0; i < got_q.size(); i++) begin
            want = ((i % W) >= 2 && (i / W) >= 2) ? interior : 0;
            total++;
            if (got_q[i] !== want * 32'h010101) begin
                bad++; $display("FAIL ramp_rule[%0d]: got %06h want %06h", i, got_q[i], want * 32'h010101);
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 2; f++) begin
            clear_queues();
            for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8'($urandom_range(0, 255));
            stream_frame(2);
            wait_drain();
            check_stream("random");
        end
    endtask

    task automatic test_out_of_line();
        clear_queues();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8'($urandom_range(0, 255));
        stream_frame(3);
        wait_drain();
        check_stream("offline");
    endtask

    task automatic test_midframe_reset();
        clear_queues();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 8'd100;
        for (int i = 0; i < 3 * W + 6; i++) send(i % W, i / W, 8'd100);
        RST = 1'b1;
        #1;
        total++;
        if (WREN !== 1'b0) begin bad++; $display("FAIL midrst_wren: got %b want 0", WREN); end
        @(posedge CLK); #1;
        READY = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        total++;
        if (WREN !== 1'b0) begin bad++; $display("FAIL midrst_release: got %b want 0", WREN); end
        clear_queues();
        repeat (8) @(posedge CLK);
        #1;
        total++;
        if (got_q.size() !== 0) begin bad++; $display("FAIL midrst_dropped: got %0d pulses want 0", got_q.size()); end
        clear_queues();
        stream_frame(0);
        wait_drain();
        total++;
        if (got_q.size() !== 128) begin bad++; $display("FAIL midrst_pulses: got %0d want 128", got_q.size()); end
        check_stream("midrst");
    endtask

    initial begin
        RST = 1'b1; READY = 1'b0; POSX = '0; POSY = '0;
        IN_R = '0; IN_G = '0; IN_B = '0;
`ifdef SOBEL_THRESHOLD_EN
        THRESH = 8'd0;
`endif
        test_reset();
        test_flat();
`ifndef SOBEL_THRESHOLD_EN
        test_step();
        test_step_gaps();
        test_ramp(8);
`else
        THRESH = 8'd9;
        test_ramp(0);
        THRESH = 8'd8;
        test_ramp(255);
        THRESH = 8'($urandom_range(1, 255));
`endif
        test_random();
        test_out_of_line();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sobel_filter.md
SOBEL_FILTER -- requirements
Module: sobel_filter

Interface
REQ-001 Parameter LINE_W, default 640: pixels per line; sizes the line buffers.
REQ-002 Parameter ADDR_W, default 12: line-buffer address width; SHALL satisfy 2^ADDR_W >= LINE_W.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 POSX  input  12  column of the pixel presented this cycle.
REQ-006 POSY  input  12  row of the pixel presented this cycle.
REQ-007 READY  input  1  upstream has a pixel available this cycle.
REQ-008 RDEN  output  1  pixel accepted this cycle.
REQ-009 IN_R, IN_G, IN_B  input  8 each  grayscale pixel (channels equal); only IN_G used.
REQ-010 WREN  output  1  OUT_* valid this cycle.
REQ-011 OUT_R, OUT_G, OUT_B  output  8 each  edge magnitude, identical on all three.

Function
REQ-012 RDEN SHALL equal READY combinationally; no backpressure; POSX, POSY, IN_G sampled in any cycle with RDEN=1.
REQ-013 Stage 1: on an accepted pixel, SHALL read line buffers LB0, LB1 at POSX (read-before-write), register column {LB1, LB0, IN_G}, then write LB0[POSX]<=IN_G and LB1[POSX]<=old LB0[POSX].
REQ-014 Stage 2: 3x3 window SHALL shift left by one column only when the stage-1 valid bit is set; idle cycles leave the window unchanged.
REQ-015 Stage 3: Gx=(right-left) with row weights 1,2,1; Gy=(bottom-top) with column weights 1,2,1; 11-bit signed.
REQ-016 Stage 4: OUT=min(|Gx|+|Gy|, 255), registered.
REQ-017 WREN SHALL assert exactly 4 cycles after each RDEN=1 cycle; one output per accepted input, in order.
REQ-018 Output is attributed to centre (POSX-1, POSY-1).
REQ-019 Border: if POSX<2 or POSY<2 at acceptance, output SHALL be 0; border flag travels with data.
REQ-020 If POSX>=LINE_W: no buffer write, output 0, WREN still asserted.
REQ-021 Row wrap (POSX returns to 0) needs no special action beyond REQ-019.

Reset
REQ-022 RST SHALL clear all valid bits, window and Gx/Gy registers, WREN=0, OUT_*=0.
REQ-023 Line-buffer RAM SHALL NOT be reset; stale contents are masked by REQ-019.
REQ-024 Reset mid-frame SHALL drop all in-flight pixels (no WREN for them); first WREN after release is 4 cycles after first RDEN.

Configuration
REQ-025 With SOBEL_THRESHOLD_EN defined: extra input THRESH [7:0]; OUT=255 when saturated magnitude >= THRESH, else 0; latency unchanged.
REQ-026 Without SOBEL_THRESHOLD_EN: THRESH absent; OUT=saturated magnitude.

Structure
REQ-027 Package filter_pkg SHALL hold pixel-width, coordinate-width (12) and saturation (255) constants, and the pipeline depth constant (4).
REQ-028 Sub-module sobel_linebuf SHALL hold the two LINE_W x 8 synchronous-read RAMs with read-before-write.

Verification
REQ-029 Flat 16x8 frame, all pixels 100, READY continuous -> every WREN carries 0; 128 WREN pulses.
REQ-030 Vertical step, 0 for x<8, 255 for x>=8 -> rows y>=2: OUT=255 at POSX=8 and POSX=9, 0 elsewhere.
REQ-031 Horizontal ramp, pixel=x -> interior outputs 8, border outputs 0.
REQ-032 Step image with READY toggling every other cycle -> identical output sequence to REQ-030; each WREN 4 cycles after its RDEN.
REQ-033 RST pulsed at pixel (5,3) -> WREN low at reset release; no outputs for dropped pixels; restart from (0,0) gives REQ-029 results.
REQ-034 SOBEL_THRESHOLD_EN, THRESH=9, ramp image -> interior 0; THRESH=8 -> interior 255.
